// File: rtl/pipeline_stage1_pkg.sv
// Shared types and helpers for pipeline stage 1: state encoding, default
// opcodes and the opcode-length rule.
package pipeline_stage1_pkg;

  typedef enum logic [2:0] {
    ST_OPCODE = 3'd0,
    ST_OPND1  = 3'd1,
    ST_OPND2  = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  localparam logic [7:0] DEF_NOP_OPCODE = 8'h00;
  localparam logic [7:0] DEF_BRK_OPCODE = 8'hFF;

  // Instruction length in bytes from the two top opcode bits.
  function automatic logic [1:0] op_len(input logic [7:0] op);
    case (op[7:6])
      2'b01:   op_len = 2'd2;
      2'b10:   op_len = 2'd3;
      default: op_len = 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/pipeline_stage1_if.sv
// Memory-side and stage-2-side signals of pipeline stage 1; master drives the
// fetch inputs, slave is the stage itself.
interface pipeline_stage1_if;
  logic [7:0] MemData;
  logic       MemValid;
  logic       BusBusy;
  logic       Flush;
  logic       Resume;
  logic       FetchInc;
  logic [7:0] PipeOut;
  logic [7:0] OperandLo;
  logic [7:0] OperandHi;
  logic       Busy;
  logic       Halted;

  modport master (
    output MemData, MemValid, BusBusy, Flush, Resume,
    input  FetchInc, PipeOut, OperandLo, OperandHi, Busy, Halted
  );

  modport slave (
    input  MemData, MemValid, BusBusy, Flush, Resume,
    output FetchInc, PipeOut, OperandLo, OperandHi, Busy, Halted
  );
endinterface

// File: rtl/pipeline_stage1_len_decode.sv
// Combinational opcode-to-length decoder (1, 2 or 3 bytes).
module pipe1_len_decode
  import pipeline_stage1_pkg::*;
(
  input  logic [7:0] op,
  output logic [1:0] len
);
  assign len = op_len(op);
endmodule

// File: rtl/pipeline_stage1.sv
// Fetch/assembly stage feeding stage 2: collects opcode and operand bytes and
// issues one opcode per instruction, NOP otherwise. Break/halt under PIPELINE_STAGE1_BREAK_EN.
module pipeline_stage1
  import pipeline_stage1_pkg::*;
#(
  parameter int         FLUSH_CYCLES = 2,
  parameter logic [7:0] NOP_OPCODE   = DEF_NOP_OPCODE,
  parameter logic [7:0] BRK_OPCODE   = DEF_BRK_OPCODE
) (
  input logic              ClockIn,
  input logic              Reset,
  pipeline_stage1_if.slave bus
);

  state_t     state_reg;
  logic [7:0] opc_reg;
  logic [7:0] lo_reg;
  logic       need_hi_reg;
  logic [2:0] cnt_reg;
  logic [7:0] pipe_out_reg;
  logic [7:0] operand_lo_reg;
  logic [7:0] operand_hi_reg;
  logic [1:0] mem_len;
  logic       fetch_state;
  logic       consume;

  pipe1_len_decode u_len (
    .op  (bus.MemData),
    .len (mem_len)
  );

  assign fetch_state = (state_reg == ST_OPCODE) || (state_reg == ST_OPND1) ||
                       (state_reg == ST_OPND2);
  assign consume     = bus.MemValid && !bus.BusBusy && !bus.Flush && !Reset && fetch_state;

  assign bus.FetchInc  = consume;
  assign bus.PipeOut   = pipe_out_reg;
  assign bus.OperandLo = operand_lo_reg;
  assign bus.OperandHi = operand_hi_reg;
  assign bus.Busy      = (state_reg == ST_OPND1) || (state_reg == ST_OPND2);

`ifdef PIPELINE_STAGE1_BREAK_EN
  logic halted_reg;
  assign bus.Halted = halted_reg;
`else
  logic unused_opt;
  assign unused_opt = bus.Resume ^ (^BRK_OPCODE);
  assign bus.Halted = 1'b0;
`endif

  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      state_reg      <= ST_OPCODE;
      opc_reg        <= '0;
      lo_reg         <= '0;
      need_hi_reg    <= 1'b0;
      cnt_reg        <= '0;
      pipe_out_reg   <= NOP_OPCODE;
      operand_lo_reg <= '0;
      operand_hi_reg <= '0;
`ifdef PIPELINE_STAGE1_BREAK_EN
      halted_reg     <= 1'b0;
`endif
    end else begin
      // Every cycle is a bubble unless an instruction issues below.
      pipe_out_reg <= NOP_OPCODE;
      if (bus.Flush) begin
        state_reg   <= ST_FLUSH;
        cnt_reg     <= 3'(FLUSH_CYCLES);
        opc_reg     <= '0;
        lo_reg      <= '0;
        need_hi_reg <= 1'b0;
`ifdef PIPELINE_STAGE1_BREAK_EN
        halted_reg  <= 1'b0;
`endif
      end else begin
        case (state_reg)
          ST_OPCODE: begin
            if (consume) begin
              if (mem_len == 2'd1) begin
                pipe_out_reg   <= bus.MemData;
                operand_lo_reg <= '0;
                operand_hi_reg <= '0;
`ifdef PIPELINE_STAGE1_BREAK_EN
                if (bus.MemData == BRK_OPCODE) begin
                  state_reg  <= ST_HALT;
                  halted_reg <= 1'b1;
                end
`endif
              end else begin
                opc_reg     <= bus.MemData;
                need_hi_reg <= (mem_len == 2'd3);
                state_reg   <= ST_OPND1;
              end
            end
          end
          ST_OPND1: begin
            if (consume) begin
              lo_reg <= bus.MemData;
              if (need_hi_reg) begin
                state_reg <= ST_OPND2;
              end else begin
                pipe_out_reg   <= opc_reg;
                operand_lo_reg <= bus.MemData;
                operand_hi_reg <= '0;
                state_reg      <= ST_OPCODE;
              end
            end
          end
          ST_OPND2: begin
            if (consume) begin
              pipe_out_reg   <= opc_reg;
              operand_lo_reg <= lo_reg;
              operand_hi_reg <= bus.MemData;
              state_reg      <= ST_OPCODE;
            end
          end
          ST_FLUSH: begin
            if (cnt_reg <= 3'd1) begin
              cnt_reg   <= '0;
              state_reg <= ST_OPCODE;
            end else begin
              cnt_reg <= cnt_reg - 3'd1;
            end
          end
`ifdef PIPELINE_STAGE1_BREAK_EN
          ST_HALT: begin
            if (bus.Resume) begin
              state_reg  <= ST_OPCODE;
              halted_reg <= 1'b0;
            end
          end
`endif
          default: state_reg <= ST_OPCODE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipeline_stage1.sv
// Directed, table-driven bench for pipeline_stage1: one cycle per record,
// FetchInc checked before the edge, registered outputs checked after it.
module tb_pipeline_stage1;

  typedef struct {
    logic [7:0] data;
    logic       mv;
    logic       bb;
    logic       fl;
    logic       rs;
    logic       re;
    logic       fi;
    logic [7:0] po;
    logic [7:0] lo;
    logic [7:0] hi;
    logic       bz;
    logic       ht;
  } vec_t;

  localparam int NVEC = 25;

  logic clk = 1'b0;
  logic rst;
  int   tests_run    = 0;
  int   tests_failed = 0;
  vec_t vecs[NVEC];

  pipeline_stage1_if bus_if ();

  pipeline_stage1 #(.FLUSH_CYCLES(2)) dut (
    .ClockIn (clk),
    .Reset   (rst),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %02h, expected %02h", nm, act, exp);
    end
  endtask

  task automatic step(input string nm, input vec_t v);
    bus_if.MemData  = v.data;
    bus_if.MemValid = v.mv;
    bus_if.BusBusy  = v.bb;
    bus_if.Flush    = v.fl;
    bus_if.Resume   = v.re;
    rst             = v.rs;
    #1;
    chk({nm, ".fetch_inc"}, {7'd0, bus_if.FetchInc}, {7'd0, v.fi});
    @(posedge clk);
    #1;
    chk({nm, ".pipe_out"}, bus_if.PipeOut, v.po);
    chk({nm, ".operand_lo"}, bus_if.OperandLo, v.lo);
    chk({nm, ".operand_hi"}, bus_if.OperandHi, v.hi);
    chk({nm, ".busy"}, {7'd0, bus_if.Busy}, {7'd0, v.bz});
    chk({nm, ".halted"}, {7'd0, bus_if.Halted}, {7'd0, v.ht});
    $display("[TB] %s data=%02h mv=%0b bb=%0b fl=%0b rs=%0b re=%0b -> fi=%0b po=%02h lo=%02h hi=%02h busy=%0b halted=%0b",
             nm, v.data, v.mv, v.bb, v.fl, v.rs, v.re, bus_if.FetchInc,
             bus_if.PipeOut, bus_if.OperandLo, bus_if.OperandHi, bus_if.Busy, bus_if.Halted);
  endtask

  initial begin
    //              data   mv    bb    fl    rs    re    fi    po     lo     hi     bz    ht
    vecs[0]  = '{8'h05, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{8'h05, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[2]  = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h07, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[3]  = '{8'h07, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    // three-byte instruction
    vecs[4]  = '{8'h85, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[5]  = '{8'h34, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[6]  = '{8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h85, 8'h34, 8'h12, 1'b0, 1'b0};
    vecs[7]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h34, 8'h12, 1'b0, 1'b0};
    // two-byte instruction with a 3-cycle bus stall
    vecs[8]  = '{8'h42, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h34, 8'h12, 1'b1, 1'b0};
    vecs[9]  = '{8'h99, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h34, 8'h12, 1'b1, 1'b0};
    vecs[10] = '{8'h99, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h34, 8'h12, 1'b1, 1'b0};
    vecs[11] = '{8'h99, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h34, 8'h12, 1'b1, 1'b0};
    vecs[12] = '{8'h99, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h42, 8'h99, 8'h00, 1'b0, 1'b0};
    // flush in OPND2
    vecs[13] = '{8'h80, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h99, 8'h00, 1'b1, 1'b0};
    vecs[14] = '{8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h99, 8'h00, 1'b1, 1'b0};
    vecs[15] = '{8'h03, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h99, 8'h00, 1'b0, 1'b0};
    vecs[16] = '{8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h99, 8'h00, 1'b0, 1'b0};
    vecs[17] = '{8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h99, 8'h00, 1'b0, 1'b0};
    vecs[18] = '{8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h03, 8'h00, 8'h00, 1'b0, 1'b0};
    // reset mid-instruction
    vecs[19] = '{8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[20] = '{8'hAA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 8'hAA, 8'h00, 1'b0, 1'b0};
    vecs[21] = '{8'h41, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'hAA, 8'h00, 1'b1, 1'b0};
    vecs[22] = '{8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[23] = '{8'h05, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[24] = '{8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hC3, 8'h00, 8'h00, 1'b0, 1'b0};

    for (int i = 0; i < NVEC; i++) begin
      step($sformatf("vec%0d", i), vecs[i]);
    end

    // Flush repeated while in FLUSH must reload the counter.
    step("reload.op",  '{8'h85, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0});
    step("reload.fl1", '{8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0});
    step("reload.fl2", '{8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0});
    step("reload.w1",  '{8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0});
    step("reload.w2",  '{8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0});
    step("reload.go",  '{8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h07, 8'h00, 8'h00, 1'b0, 1'b0});

`ifdef PIPELINE_STAGE1_BREAK_EN
    step("brk.issue",  '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b1});
    step("brk.hold1",  '{8'h05, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1});
    step("brk.hold2",  '{8'h05, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1});
    step("brk.resume", '{8'h05, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0});
    step("brk.next",   '{8'h05, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0});
    step("brk.again",  '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b1});
    step("brk.flush",  '{8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0});
    step("brk.fw1",    '{8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0});
    step("brk.fw2",    '{8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0});
    step("brk.after",  '{8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h07, 8'h00, 8'h00, 1'b0, 1'b0});
`else
    step("brk.plain",  '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0});
    step("brk.next",   '{8'h05, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0});
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
